// File: rtl/obi_arb_pkg.sv
// Shared types for the OBI initiator-port arbiter: FSM states and the
// registered request payload.
package obi_arb_pkg;

  // Payload fields are sized for the widest supported bus; the top module
  // zero-extends on capture and slices back to its configured widths.
  localparam int unsigned ARB_AW_MAX = 64;
  localparam int unsigned ARB_DW_MAX = 64;
  localparam int unsigned ARB_BE_MAX = ARB_DW_MAX / 8;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP,
    DRAIN
  } arb_state_e;

  typedef struct packed {
    logic [ARB_AW_MAX-1:0] addr;
    logic                  we;
    logic [ARB_BE_MAX-1:0] be;
    logic [ARB_DW_MAX-1:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/obi_rr_pick.sv
// Rotating priority encoder: the search starts just after the last winner
// and wraps modulo NUM_REQ.
module obi_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [IW-1:0]      o_winner,
  output logic               o_any
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      // last <= NUM_REQ-1 and k <= NUM_REQ, so one subtraction wraps the sum
      w_sum = {1'b0, i_last} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IW+1)'(NUM_REQ);
      end
      w_idx = w_sum[IW-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_winner = w_idx;
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/obi_icn_arbiter.sv
// Round-robin arbiter sharing one OBI initiator port among NUM_REQ requesters,
// one outstanding transaction, with a response timeout that answers with an error.
module obi_icn_arbiter
  import obi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned OBI_AW    = 32,
  parameter int unsigned OBI_DW    = 32,
  parameter int unsigned OBI_IDW   = 1,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_req,
  input  logic [NUM_REQ-1:0][OBI_AW-1:0]     req_addr,
  input  logic [NUM_REQ-1:0]                 req_we,
  input  logic [NUM_REQ-1:0][OBI_DW/8-1:0]   req_be,
  input  logic [NUM_REQ-1:0][OBI_DW-1:0]     req_wdata,
  input  logic [NUM_REQ-1:0]                 req_rready,
  output logic [NUM_REQ-1:0]                 req_gnt,
  output logic [NUM_REQ-1:0]                 req_rvalid,
  output logic [OBI_DW-1:0]                  req_rdata,
  output logic                               req_err,
  output logic                               obi_req,
  output logic                               obi_reqpar,
  output logic [OBI_AW-1:0]                  obi_addr,
  output logic                               obi_we,
  output logic [OBI_DW/8-1:0]                obi_be,
  output logic [OBI_DW-1:0]                  obi_wdata,
  output logic [OBI_IDW-1:0]                 obi_aid,
  output logic                               obi_rready,
  output logic                               obi_rreadypar,
  input  logic                               obi_gnt,
  input  logic                               obi_rvalid,
  input  logic [OBI_DW-1:0]                  obi_rdata,
  input  logic                               obi_err,
  input  logic [OBI_IDW-1:0]                 obi_rid,
  output logic                               timeout_pulse
);

  localparam int unsigned IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BEW = OBI_DW / 8;

  arb_state_e           r_state;
  arb_req_t             r_req;
  logic [IW-1:0]        r_win;
  logic [IW-1:0]        r_last;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 r_obi_req;

  logic [IW-1:0]        w_pick;
  logic                 w_any;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic                 w_rready;
  logic                 w_fire;
  logic                 w_tmo;
  logic                 w_unused;

  obi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .i_req    (req_req),
    .i_last   (r_last),
    .o_winner (w_pick),
    .o_any    (w_any)
  );

  always_comb begin
    w_win_oh = NUM_REQ'(1) << r_win;
    w_rready = 1'b0;
    case (r_state)
      RESP:    w_rready = req_rready[r_win];
      DRAIN:   w_rready = 1'b1;
      default: w_rready = 1'b0;
    endcase
    w_fire = (r_state == RESP) && obi_rvalid && w_rready;
    // a response accepted in the limit cycle takes precedence over the timeout
    w_tmo  = (r_state == RESP) && !w_fire && (r_cnt == '1);
  end

  assign req_gnt       = ((r_state == ADDR) && obi_gnt) ? w_win_oh : '0;
  assign req_rvalid    = (w_fire || w_tmo) ? w_win_oh : '0;
  assign req_rdata     = w_fire ? obi_rdata : '0;
  assign req_err       = w_fire ? obi_err : w_tmo;
  assign timeout_pulse = w_tmo;

  assign obi_req       = r_obi_req;
  assign obi_reqpar    = ~r_obi_req;
  assign obi_addr      = r_req.addr[OBI_AW-1:0];
  assign obi_we        = r_req.we;
  assign obi_be        = r_req.be[BEW-1:0];
  assign obi_wdata     = r_req.wdata[OBI_DW-1:0];
  assign obi_aid       = '0;
  assign obi_rready    = w_rready;
  assign obi_rreadypar = ~w_rready;

  // response ID is not needed with a single outstanding transaction
  assign w_unused = ^{obi_rid, r_req};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_win     <= '0;
      r_last    <= IW'(NUM_REQ - 1);
      r_cnt     <= '0;
      r_obi_req <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_win       <= w_pick;
            r_req.addr  <= ARB_AW_MAX'(req_addr[w_pick]);
            r_req.we    <= req_we[w_pick];
            r_req.be    <= ARB_BE_MAX'(req_be[w_pick]);
            r_req.wdata <= ARB_DW_MAX'(req_wdata[w_pick]);
            r_obi_req   <= 1'b1;
            r_state     <= ADDR;
          end
        end
        ADDR: begin
          if (obi_gnt) begin
            r_obi_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= RESP;
          end
        end
        RESP: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_fire) begin
            r_last  <= r_win;
            r_state <= IDLE;
          end else if (w_tmo) begin
            r_last  <= r_win;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (obi_rvalid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_icn_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level
// reference model of the arbiter, checked every cycle.
module tb_obi_icn_arbiter;

  localparam int NR = 2;
  localparam int TW = 4;
  localparam int TMO_LIMIT = (1 << TW) - 1;

  localparam int P_IDLE  = 0;
  localparam int P_ADDR  = 1;
  localparam int P_RESP  = 2;
  localparam int P_DRAIN = 3;

  logic                clk;
  logic                reset;
  logic [NR-1:0]       req_req;
  logic [NR-1:0][31:0] req_addr;
  logic [NR-1:0]       req_we;
  logic [NR-1:0][3:0]  req_be;
  logic [NR-1:0][31:0] req_wdata;
  logic [NR-1:0]       req_rready;
  logic [NR-1:0]       req_gnt;
  logic [NR-1:0]       req_rvalid;
  logic [31:0]         req_rdata;
  logic                req_err;
  logic                obi_req;
  logic                obi_reqpar;
  logic [31:0]         obi_addr;
  logic                obi_we;
  logic [3:0]          obi_be;
  logic [31:0]         obi_wdata;
  logic [0:0]          obi_aid;
  logic                obi_rready;
  logic                obi_rreadypar;
  logic                obi_gnt;
  logic                obi_rvalid;
  logic [31:0]         obi_rdata;
  logic                obi_err;
  logic [0:0]          obi_rid;
  logic                timeout_pulse;

  int total = 0;
  int bad   = 0;

  obi_icn_arbiter #(
    .NUM_REQ   (NR),
    .OBI_AW    (32),
    .OBI_DW    (32),
    .OBI_IDW   (1),
    .TIMEOUT_W (TW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_req       (req_req),
    .req_addr      (req_addr),
    .req_we        (req_we),
    .req_be        (req_be),
    .req_wdata     (req_wdata),
    .req_rready    (req_rready),
    .req_gnt       (req_gnt),
    .req_rvalid    (req_rvalid),
    .req_rdata     (req_rdata),
    .req_err       (req_err),
    .obi_req       (obi_req),
    .obi_reqpar    (obi_reqpar),
    .obi_addr      (obi_addr),
    .obi_we        (obi_we),
    .obi_be        (obi_be),
    .obi_wdata     (obi_wdata),
    .obi_aid       (obi_aid),
    .obi_rready    (obi_rready),
    .obi_rreadypar (obi_rreadypar),
    .obi_gnt       (obi_gnt),
    .obi_rvalid    (obi_rvalid),
    .obi_rdata     (obi_rdata),
    .obi_err       (obi_err),
    .obi_rid       (obi_rid),
    .timeout_pulse (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_phase = P_IDLE;
  int          m_last  = NR - 1;
  int          m_win   = 0;
  int          m_cnt   = 0;
  logic [31:0] m_addr, m_wdata;
  logic        m_we;
  logic [3:0]  m_be;

  always @(negedge clk) begin
    logic [NR-1:0] e_oh, e_gnt, e_rv;
    logic          e_req, e_rr, fire, tmo, found;
    #2;
    if (reset) begin
      m_phase = P_IDLE;
      m_last  = NR - 1;
      m_cnt   = 0;
    end
    e_oh  = '0;
    e_oh[m_win] = 1'b1;
    e_req = (m_phase == P_ADDR);
    e_gnt = (e_req && obi_gnt) ? e_oh : '0;
    e_rr  = (m_phase == P_RESP) ? req_rready[m_win] : (m_phase == P_DRAIN);
    fire  = (m_phase == P_RESP) && obi_rvalid && e_rr;
    tmo   = (m_phase == P_RESP) && !fire && (m_cnt == TMO_LIMIT);
    e_rv  = (fire || tmo) ? e_oh : '0;

    chk("m_obi_req",    obi_req, e_req);
    chk("m_reqpar",     obi_reqpar, !e_req);
    chk("m_gnt",        req_gnt, e_gnt);
    chk("m_rready",     obi_rready, e_rr);
    chk("m_rreadypar",  obi_rreadypar, !e_rr);
    chk("m_rvalid",     req_rvalid, e_rv);
    chk("m_rdata",      req_rdata, fire ? obi_rdata : 32'h0);
    chk("m_err",        req_err, fire ? obi_err : tmo);
    chk("m_timeout",    timeout_pulse, tmo);
    chk("m_aid",        obi_aid, 1'b0);
    if (e_req) begin
      chk("m_addr",  obi_addr, m_addr);
      chk("m_we",    obi_we, m_we);
      chk("m_be",    obi_be, m_be);
      chk("m_wdata", obi_wdata, m_wdata);
    end
    if (reset) begin
      chk("m_rst_addr", obi_addr, 32'h0);
      chk("m_rst_wdata", obi_wdata, 32'h0);
      chk("m_rst_be", {obi_we, obi_be}, 5'h0);
    end

    if (!reset) begin
      case (m_phase)
        P_IDLE: begin
          found = 1'b0;
          for (int k = 1; k <= NR; k++) begin
            int i;
            i = (m_last + k) % NR;
            if (!found && req_req[i]) begin
              found   = 1'b1;
              m_win   = i;
              m_addr  = req_addr[i];
              m_we    = req_we[i];
              m_be    = req_be[i];
              m_wdata = req_wdata[i];
              m_phase = P_ADDR;
            end
          end
        end
        P_ADDR: if (obi_gnt) begin
          m_phase = P_RESP;
          m_cnt   = 0;
        end
        P_RESP: begin
          if (fire) begin
            m_last  = m_win;
            m_phase = P_IDLE;
          end else if (tmo) begin
            m_last  = m_win;
            m_phase = P_DRAIN;
          end else begin
            m_cnt++;
          end
        end
        default: if (obi_rvalid) m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic quiet();
    req_req    = '0;
    req_we     = '0;
    req_rready = '0;
    obi_gnt    = 1'b0;
    obi_rvalid = 1'b0;
    obi_err    = 1'b0;
    obi_rdata  = '0;
  endtask

  logic [NR-1:0] rv_q[$];
  int            prob_rv;

  initial begin
    reset     = 1'b1;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
    obi_rid   = '0;
    quiet();

    cyc(); cyc();
    reset = 1'b0;
    #3;
    chk("rst_obi_req", obi_req, 1'b0);
    chk("rst_parity", {obi_reqpar, obi_rreadypar}, 2'b11);

    // 1: both requesters read, immediate grant and response, alternation
    cyc();
    req_req     = 2'b11;
    req_addr[0] = 32'h0105_1000;
    req_addr[1] = 32'h0105_1000;
    req_be[0]   = 4'hF;
    req_be[1]   = 4'hF;
    obi_gnt     = 1'b1;
    obi_rvalid  = 1'b1;
    obi_rdata   = 32'hDEAD_BEEF;
    req_rready  = 2'b11;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) cyc();
      #3;
      if (i == 1) begin
        chk("t1_first_gnt", req_gnt, 2'b01);
        chk("t1_addr", obi_addr, 32'h0105_1000);
      end
      if (req_rvalid != '0) begin
        if (rv_q.size() == 0) begin
          chk("t1_first_rdata", req_rdata, 32'hDEAD_BEEF);
          chk("t1_first_err", req_err, 1'b0);
        end
        rv_q.push_back(req_rvalid);
      end
    end
    chk("t1_count", rv_q.size(), 10);
    for (int j = 0; j < rv_q.size(); j++) begin
      chk("t1_order", rv_q[j], (j % 2 == 0) ? 2'b01 : 2'b10);
    end

    // 2: requester 1 write held in ADDR by a late grant
    cyc(); quiet();
    cyc();
    req_req      = 2'b10;
    req_we       = 2'b10;
    req_addr[1]  = 32'h0105_2000;
    req_be[1]    = 4'h3;
    req_wdata[1] = 32'hA5A5_A5A5;
    req_rready   = 2'b11;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 1) begin
        req_req      = 2'b00;
        req_wdata[1] = 32'h0;
        req_be[1]    = 4'h0;
      end
      #3;
      chk("t2_req_held", obi_req, 1'b1);
      chk("t2_wdata", obi_wdata, 32'hA5A5_A5A5);
      chk("t2_be_we", {obi_we, obi_be}, 5'h13);
      chk("t2_no_gnt", req_gnt, 2'b00);
    end
    cyc(); obi_gnt = 1'b1; #3;
    chk("t2_gnt", req_gnt, 2'b10);
    cyc(); obi_gnt = 1'b0; obi_rvalid = 1'b1; #3;
    chk("t2_rvalid", req_rvalid, 2'b10);
    cyc(); quiet(); #3;
    chk("t2_idle", obi_req, 1'b0);

    // 3: hung read times out, late response swallowed, then normal read
    cyc();
    req_req     = 2'b01;
    req_addr[0] = 32'h0105_3000;
    req_rready  = 2'b11;
    obi_gnt     = 1'b1;
    cyc(); req_req = 2'b00; #3;
    chk("t3_gnt", req_gnt, 2'b01);
    for (int i = 2; i <= 16; i++) begin
      cyc(); #3;
      if (i == 16) chk("t3_no_early_tmo", {timeout_pulse, req_rvalid}, 3'b000);
    end
    cyc(); #3;
    chk("t3_tmo_rvalid", req_rvalid, 2'b01);
    chk("t3_tmo_err", req_err, 1'b1);
    chk("t3_tmo_rdata", req_rdata, 32'h0);
    chk("t3_tmo_pulse", timeout_pulse, 1'b1);
    cyc(); obi_rvalid = 1'b1; obi_rdata = 32'h1234_5678; #3;
    chk("t3_drain_rready", obi_rready, 1'b1);
    chk("t3_drain_swallow", req_rvalid, 2'b00);
    cyc(); obi_rvalid = 1'b0; req_req = 2'b01; obi_rdata = 32'hCAFE_F00D; #3;
    chk("t3_back_idle", obi_req, 1'b0);
    cyc(); #3;
    chk("t3_next_gnt", req_gnt, 2'b01);
    cyc(); obi_rvalid = 1'b1; #3;
    chk("t3_next_rvalid", req_rvalid, 2'b01);
    chk("t3_next_rdata", req_rdata, 32'hCAFE_F00D);
    cyc(); quiet();

    // 4: downstream error response
    cyc();
    req_req     = 2'b10;
    req_we      = 2'b00;
    req_addr[1] = 32'h0106_0000;
    req_rready  = 2'b11;
    obi_gnt     = 1'b1;
    cyc(); #3;
    chk("t4_addr", obi_addr, 32'h0106_0000);
    cyc(); obi_rvalid = 1'b1; obi_err = 1'b1; obi_rdata = 32'h0BAD_0BAD; #3;
    chk("t4_rvalid", req_rvalid, 2'b10);
    chk("t4_err", req_err, 1'b1);
    cyc();
    obi_rvalid  = 1'b0;
    obi_err     = 1'b0;
    obi_gnt     = 1'b0;
    req_req     = 2'b01;
    req_addr[0] = 32'h0105_4000;
    #3;
    chk("t4_idle", {obi_req, obi_rready}, 2'b00);
    cyc(); #3;
    chk("t4_rearb", obi_req, 1'b1);

    // 5: requester holds off its response for three cycles
    cyc(); obi_gnt = 1'b1; #3;
    chk("t5_gnt", req_gnt, 2'b01);
    for (int i = 0; i < 3; i++) begin
      cyc();
      obi_gnt    = 1'b0;
      obi_rvalid = 1'b1;
      obi_rdata  = 32'h55AA_1234;
      req_rready = 2'b00;
      #3;
      chk("t5_hold_rvalid", req_rvalid, 2'b00);
      chk("t5_hold_rready", obi_rready, 1'b0);
    end
    cyc(); req_rready = 2'b01; #3;
    chk("t5_release", {obi_rready, req_rvalid}, 3'b101);
    chk("t5_rdata", req_rdata, 32'h55AA_1234);
    cyc(); quiet(); #3;
    chk("t5_idle", obi_rready, 1'b0);

    // 6: reset in the middle of a response wait
    cyc();
    req_req    = 2'b11;
    req_rready = 2'b11;
    obi_gnt    = 1'b1;
    cyc(); #3;
    chk("t6_gnt1", req_gnt, 2'b10);
    cyc(); #3;
    chk("t6_resp_rready", obi_rready, 1'b1);
    cyc(); reset = 1'b1; #3;
    chk("t6_rst_outs", {obi_req, obi_rready, req_gnt, req_rvalid, req_err, timeout_pulse}, 8'h0);
    chk("t6_rst_par", {obi_reqpar, obi_rreadypar}, 2'b11);
    chk("t6_rst_payload", {obi_addr, obi_wdata}, 64'h0);
    cyc();
    cyc(); reset = 1'b0;
    cyc(); #3;
    chk("t6_prio0", req_gnt, 2'b01);
    cyc(); quiet();
    cyc();

    // randomized traffic with varying response likelihood
    for (int seg = 0; seg < 6; seg++) begin
      case (seg)
        0: prob_rv = 40;
        1: prob_rv = 4;
        2: prob_rv = 75;
        3: prob_rv = 15;
        4: prob_rv = 0;
        default: prob_rv = 50;
      endcase
      for (int c = 0; c < 500; c++) begin
        cyc();
        reset = ($urandom_range(0, 399) == 0);
        req_req = NR'($urandom);
        for (int r = 0; r < NR; r++) begin
          req_addr[r]   = $urandom;
          req_wdata[r]  = $urandom;
          req_be[r]     = 4'($urandom);
          req_we[r]     = 1'($urandom);
          req_rready[r] = ($urandom_range(0, 99) < 80);
        end
        obi_gnt    = ($urandom_range(0, 99) < 70);
        obi_rvalid = ($urandom_range(0, 99) < prob_rv);
        obi_err    = ($urandom_range(0, 99) < 20);
        obi_rdata  = $urandom;
      end
    end
    cyc(); reset = 1'b0; quiet();
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
